// File: rtl/coin_sched.sv
// Two-slot coin scheduler: round-robin arbitration into a small FIFO, replayed
// to the vending core as code/gap pairs, with saturating vend/change tallies.
module coin_sched #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             r,
   input  logic             a_req,
   input  logic             a_dime,
   output logic             a_ack,
   input  logic             b_req,
   input  logic             b_dime,
   output logic             b_ack,
   input  logic             cancel,
   output logic             x1,
   output logic             x0,
   input  logic             z1,
   input  logic             z0,
   output logic             core_r,
   output logic [CNT_W-1:0] vend_cnt,
   output logic [CNT_W-1:0] chg_cnt,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, COIN, GAP} state_t;

   state_t           state, state_nx;
   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wptr, rptr;
   logic [AW:0]      count;
   logic             prio_b;
   logic             open, push, push_dime, pop, sample;
   logic [1:0]       code_nx;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // prio_b set means A was granted last, so B wins a tie.
   assign open      = !full && !cancel && !r;
   assign a_ack     = open && a_req && (!b_req || !prio_b);
   assign b_ack     = open && b_req && (!a_req || prio_b);
   assign push      = a_ack || b_ack;
   assign push_dime = a_ack ? a_dime : b_dime;

   always_comb begin
      state_nx = state;
      code_nx  = 2'b00;
      pop      = 1'b0;
      sample   = 1'b0;
      case (state)
         IDLE: if (!empty) begin
            pop      = 1'b1;
            state_nx = COIN;
            code_nx  = {mem[rptr], 1'b1};
         end
         COIN: state_nx = GAP;
         GAP: begin
            sample = 1'b1;
            if (!empty) begin
               pop      = 1'b1;
               state_nx = COIN;
               code_nx  = {mem[rptr], 1'b1};
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // A cancelled transaction discards its response and any pending coins.
      if (cancel) begin
         pop      = 1'b0;
         sample   = 1'b0;
         state_nx = IDLE;
         code_nx  = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state    <= IDLE;
         x1       <= 1'b0;
         x0       <= 1'b0;
         core_r   <= 1'b0;
         mem      <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         prio_b   <= 1'b0;
         vend_cnt <= '0;
         chg_cnt  <= '0;
      end else begin
         state      <= state_nx;
         {x1, x0}   <= code_nx;
         core_r     <= cancel;
         if (push) begin
            mem[wptr] <= push_dime;
            wptr      <= wptr + 1'b1;
         end
         if (cancel) begin
            rptr  <= wptr;
            count <= '0;
         end else begin
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         if (a_ack)      prio_b <= 1'b1;
         else if (b_ack) prio_b <= 1'b0;
         if (sample && z1 && (vend_cnt != '1)) vend_cnt <= vend_cnt + 1'b1;
         if (sample && z0 && (chg_cnt  != '1)) chg_cnt  <= chg_cnt + 1'b1;
      end
   end
endmodule
